sdram_init_seq: RTL

SDRAM_INIT_SEQ -- requirements
Module: sdram_init_seq

---
 rtl/sdram_pkg.sv | 34 +++
 rtl/sdram_init_seq_if.sv | 31 +++
 rtl/sdram_init_seq_timer.sv | 29 ++
 rtl/sdram_init_seq.sv | 126 ++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command codes, init-sequencer states and a
// small helper for sizing the init timer.
package sdram_pkg;

  typedef enum logic [3:0] {
    CMD_NOP   = 4'd0,
    CMD_ACT   = 4'd1,
    CMD_READ  = 4'd2,
    CMD_WRITE = 4'd3,
    CMD_PALL  = 4'd4,
    CMD_REF   = 4'd5,
    CMD_MRS   = 4'd6
  } sdram_cmd_e;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_PALL_REQ,
    ST_PALL_WAIT,
    ST_REF,
    ST_REF_WAIT,
    ST_MRS,
    ST_MRS_WAIT,
    ST_DONE
  } init_state_e;

  localparam int MODE_ADDR_W = 13;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sdram_init_seq_if.sv
// Handshake and command bundle between the init sequencer (master) and the
// precharge sequencer / SDRAM command mux (slave).
interface sdram_init_seq_if;
  import sdram_pkg::*;

  logic                   reinit;
  logic                   pall_done;
  logic                   pall_start;
  sdram_cmd_e             command;
  logic [MODE_ADDR_W-1:0] mode_addr;
  logic                   init_done;

  modport master (
    input  reinit,
    input  pall_done,
    output pall_start,
    output command,
    output mode_addr,
    output init_done
  );

  modport slave (
    output reinit,
    output pall_done,
    input  pall_start,
    input  command,
    input  mode_addr,
    input  init_done
  );

endinterface

// File: rtl/sdram_init_seq_timer.sv
// Loadable down-counter shared by all timed init states; stops at zero and
// flags the cycle on which the count is 1.
module init_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic             one_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign one_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialization sequencer: NOP wait, precharge-all, N
// auto-refreshes, mode register set, then DONE until a reinit request.
//
// state        | meaning
// POWERUP      | NOP wait after reset, POWERUP_CYCLES long
// PALL_REQ     | one-cycle start pulse to the precharge-all sequencer
// PALL_WAIT    | wait for pall_done
// REF          | issue one auto-refresh
// REF_WAIT     | tRFC spacing, then next REF or MRS
// MRS          | issue mode register set with MODE_VALUE
// MRS_WAIT     | tMRD spacing before DONE
// DONE         | init_done high; reinit restarts at PALL_REQ
module sdram_init_seq
  import sdram_pkg::*;
#(
  parameter int                     POWERUP_CYCLES = 20000,
  parameter int                     TRFC_CYCLES    = 7,
  parameter int                     TMRD_CYCLES    = 2,
  parameter int                     NUM_REFRESH    = 8,
  parameter logic [MODE_ADDR_W-1:0] MODE_VALUE     = 13'h033
) (
  input logic              clk,
  input logic              n_rst,
  sdram_init_seq_if.master bus
);

  // Sized for the longest load so short power-up values stay legal.
  localparam int MAX_LOAD = max3(POWERUP_CYCLES, TRFC_CYCLES - 1, TMRD_CYCLES - 1);
  localparam int TW       = $clog2(MAX_LOAD + 1);

  if (POWERUP_CYCLES < 1) begin : g_bad_powerup
    $error("POWERUP_CYCLES must be >= 1");
  end
  if (TRFC_CYCLES < 2) begin : g_bad_trfc
    $error("TRFC_CYCLES must be >= 2");
  end
  if (TMRD_CYCLES < 2) begin : g_bad_tmrd
    $error("TMRD_CYCLES must be >= 2");
  end
  if (NUM_REFRESH < 1 || NUM_REFRESH > 15) begin : g_bad_nref
    $error("NUM_REFRESH must be in 1..15");
  end

  init_state_e state_q, state_d;
  logic [3:0]  ref_cnt_q, ref_cnt_d;
  logic        tmr_load;
  logic [TW-1:0] tmr_value;
  logic        tmr_one;

  init_timer #(.WIDTH(TW)) u_timer (
    .clk          (clk),
    .load_i       (tmr_load),
    .load_value_i (tmr_value),
    .one_o        (tmr_one)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= ST_POWERUP;
      ref_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      ref_cnt_q <= ref_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ref_cnt_d      = ref_cnt_q;
    tmr_load       = 1'b0;
    tmr_value      = '0;
    bus.pall_start = 1'b0;
    bus.command    = CMD_NOP;
    bus.mode_addr  = '0;
    bus.init_done  = 1'b0;

    unique case (state_q)
      ST_POWERUP: begin
        if (tmr_one) state_d = ST_PALL_REQ;
      end
      ST_PALL_REQ: begin
        bus.pall_start = 1'b1;
        state_d        = ST_PALL_WAIT;
      end
      ST_PALL_WAIT: begin
        if (bus.pall_done) state_d = ST_REF;
      end
      ST_REF: begin
        bus.command = CMD_REF;
        ref_cnt_d   = ref_cnt_q + 4'd1;
        tmr_load    = 1'b1;
        tmr_value   = TW'(TRFC_CYCLES - 1);
        state_d     = ST_REF_WAIT;
      end
      ST_REF_WAIT: begin
        if (tmr_one) begin
          state_d = (ref_cnt_q < 4'(NUM_REFRESH)) ? ST_REF : ST_MRS;
        end
      end
      ST_MRS: begin
        bus.command   = CMD_MRS;
        bus.mode_addr = MODE_VALUE;
        tmr_load      = 1'b1;
        tmr_value     = TW'(TMRD_CYCLES - 1);
        state_d       = ST_MRS_WAIT;
      end
      ST_MRS_WAIT: begin
        if (tmr_one) state_d = ST_DONE;
      end
      ST_DONE: begin
        bus.init_done = 1'b1;
        if (bus.reinit) begin
          ref_cnt_d = 4'd0;
          state_d   = ST_PALL_REQ;
        end
      end
    endcase

    // Reset re-arms the power-up wait so POWERUP always runs its full length.
    if (!n_rst) begin
      tmr_load  = 1'b1;
      tmr_value = TW'(POWERUP_CYCLES);
    end
  end

endmodule
